// File: rtl/mat_vec_arbiter.sv
// mat_vec_arbiter: round-robin front end sharing one 4x4 matrix-vector
// unit between two requesters, one operation in flight, sticky timeout flag.
module mat_vec_arbiter #(
    parameter int DATAWIDTH = 32,
    parameter int TIMEOUT   = 15
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                req_valid_0,
    output logic                                req_ready_0,
    input  logic [3:0][3:0][DATAWIDTH-1:0]      req_A_0,
    input  logic [3:0][DATAWIDTH-1:0]           req_x_0,
    input  logic                                req_valid_1,
    output logic                                req_ready_1,
    input  logic [3:0][3:0][DATAWIDTH-1:0]      req_A_1,
    input  logic [3:0][DATAWIDTH-1:0]           req_x_1,
    output logic                                rsp_valid_0,
    input  logic                                rsp_ready_0,
    output logic [3:0][DATAWIDTH-1:0]           rsp_y_0,
    output logic                                rsp_valid_1,
    input  logic                                rsp_ready_1,
    output logic [3:0][DATAWIDTH-1:0]           rsp_y_1,
    output logic [3:0][3:0][DATAWIDTH-1:0]      mv_A,
    output logic [3:0][DATAWIDTH-1:0]           mv_x,
    output logic                                mv_i_dv,
    input  logic [3:0][DATAWIDTH-1:0]           mv_y,
    input  logic                                mv_o_dv,
    input  logic                                mv_o_ready,
    output logic                                err
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        BUSY = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic owner_q, owner_d;
    logic last_q, last_d;
    logic err_q, err_d;
    logic [3:0][DATAWIDTH-1:0] y0_q, y0_d;
    logic [3:0][DATAWIDTH-1:0] y1_q, y1_d;

    logic issue;
    logic pick;
    logic owner_ack;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ARB;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
            y0_q    <= '0;
            y1_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            err_q   <= err_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
        end
    end

    // Tie goes to whoever did not win last; a lone request always wins.
    always_comb begin
        pick = 1'b0;
        if (req_valid_0 && req_valid_1) begin
            pick = ~last_q;
        end else begin
            pick = req_valid_1;
        end
    end

    // rstn gates the issue so no handshake leaks out while held in reset.
    assign issue = rstn && (state_q == ARB) && mv_o_ready
                   && (req_valid_0 || req_valid_1);

    assign owner_ack = owner_q ? rsp_ready_1 : rsp_ready_0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        err_d   = err_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        unique case (state_q)
            ARB: begin
                if (issue) begin
                    state_d = BUSY;
                    owner_d = pick;
                    last_d  = pick;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (mv_o_dv) begin
                    state_d = CAPT;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ARB;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAPT: begin
                if (owner_q) begin
                    y1_d = mv_y;
                end else begin
                    y0_d = mv_y;
                end
                state_d = RESP;
            end
            RESP: begin
                if (owner_ack) begin
                    state_d = ARB;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    assign mv_i_dv     = issue;
    assign req_ready_0 = issue && !pick;
    assign req_ready_1 = issue && pick;
    assign mv_A        = (issue && pick) ? req_A_1 : req_A_0;
    assign mv_x        = (issue && pick) ? req_x_1 : req_x_0;

    assign rsp_valid_0 = (state_q == RESP) && !owner_q;
    assign rsp_valid_1 = (state_q == RESP) && owner_q;
    assign rsp_y_0     = y0_q;
    assign rsp_y_1     = y1_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mat_vec_arbiter.sv
// tb_mat_vec_arbiter: directed pins plus randomized traffic checked every
// cycle against a transaction-level model of the arbiter and the unit.
module tb_mat_vec_arbiter;

    localparam int DW  = 32;
    localparam int TMO = 15;

    typedef logic [3:0][3:0][DW-1:0] mat_t;
    typedef logic [3:0][DW-1:0] vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic req_valid_0 = 1'b0;
    logic req_valid_1 = 1'b0;
    mat_t req_A_0 = '0;
    mat_t req_A_1 = '0;
    vec_t req_x_0 = '0;
    vec_t req_x_1 = '0;
    logic rsp_ready_0 = 1'b0;
    logic rsp_ready_1 = 1'b0;
    logic mv_o_dv = 1'b0;
    logic mv_o_ready = 1'b1;
    vec_t mv_y = '0;

    logic req_ready_0, req_ready_1;
    logic rsp_valid_0, rsp_valid_1;
    vec_t rsp_y_0, rsp_y_1;
    mat_t mv_A;
    vec_t mv_x;
    logic mv_i_dv;
    logic err;

    mat_vec_arbiter #(.DATAWIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0),
        .req_A_0(req_A_0), .req_x_0(req_x_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
        .req_A_1(req_A_1), .req_x_1(req_x_1),
        .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0),
        .rsp_y_0(rsp_y_0),
        .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1),
        .rsp_y_1(rsp_y_1),
        .mv_A(mv_A), .mv_x(mv_x), .mv_i_dv(mv_i_dv),
        .mv_y(mv_y), .mv_o_dv(mv_o_dv), .mv_o_ready(mv_o_ready),
        .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    bit chk_en = 1'b1;

    // Transaction model: stage 0 idle, 1 unit working, 2 result due, 3 held.
    int   stage = 0;
    bit   owner = 1'b0;
    bit   last = 1'b1;
    bit   m_err = 1'b0;
    vec_t m_resp [2];
    vec_t sb_y = '0;
    int   waited = 0;

    // Unit environment: delay 0 means the unit never answers.
    int   unit_delay = 5;
    int   u_left = 0;
    bit   y_due = 1'b0;
    vec_t u_res = '0;
    bit   spur_en = 1'b0;

    task automatic chk(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mvmul(input mat_t a, input vec_t x);
        vec_t y;
        for (int i = 0; i < 4; i++) begin
            y[i] = '0;
            for (int j = 0; j < 4; j++) begin
                y[i] = y[i] + a[i][j] * x[j];
            end
        end
        return y;
    endfunction

    function automatic bit grant_ok();
        return (stage == 0) && rstn && mv_o_ready
               && (req_valid_0 || req_valid_1);
    endfunction

    function automatic bit grant_who();
        if (req_valid_0 && req_valid_1) begin
            return ~last;
        end
        return req_valid_1;
    endfunction

    always @(posedge clk) begin : model
        bit go, g;
        cyc++;
        if (!rstn) begin
            stage = 0;
            owner = 1'b0;
            last = 1'b1;
            m_err = 1'b0;
            m_resp[0] = '0;
            m_resp[1] = '0;
            waited = 0;
            u_left = 0;
            y_due = 1'b0;
        end else begin
            go = grant_ok();
            g = grant_who();
            y_due = (u_left == 1);
            if (u_left > 0) u_left--;
            case (stage)
                0: if (go) begin
                    owner = g;
                    last = g;
                    stage = 1;
                    waited = 0;
                    sb_y = g ? mvmul(req_A_1, req_x_1)
                             : mvmul(req_A_0, req_x_0);
                    u_res = sb_y;
                    u_left = unit_delay;
                end
                1: begin
                    waited++;
                    if (mv_o_dv) begin
                        stage = 2;
                    end else if (waited == TMO) begin
                        m_err = 1'b1;
                        stage = 0;
                    end
                end
                2: begin
                    m_resp[owner] = mv_y;
                    stage = 3;
                end
                3: if (owner ? rsp_ready_1 : rsp_ready_0) stage = 0;
                default: stage = 0;
            endcase
        end
    end

    always @(negedge clk) begin : unit_drv
        vec_t junk;
        for (int i = 0; i < 4; i++) junk[i] = $urandom();
        mv_o_dv = (u_left == 1)
                  || (spur_en && u_left == 0 && stage != 1
                      && $urandom_range(0, 7) == 0);
        mv_y = y_due ? u_res : junk;
    end

    always @(negedge clk) begin : compare
        bit go, g, rv0, rv1;
        #1;
        if (chk_en) begin
            go = grant_ok();
            g = grant_who();
            chk("mv_i_dv", mv_i_dv, go);
            chk("req_ready_0", req_ready_0, go && !g);
            chk("req_ready_1", req_ready_1, go && g);
            chk("mv_A", mv_A, (go && g) ? req_A_1 : req_A_0);
            chk("mv_x", mv_x, (go && g) ? req_x_1 : req_x_0);
            rv0 = rstn && stage == 3 && !owner;
            rv1 = rstn && stage == 3 && owner;
            chk("rsp_valid_0", rsp_valid_0, rv0);
            chk("rsp_valid_1", rsp_valid_1, rv1);
            chk("rsp_y_0", rsp_y_0, rstn ? m_resp[0] : '0);
            chk("rsp_y_1", rsp_y_1, rstn ? m_resp[1] : '0);
            chk("err", err, rstn ? m_err : 1'b0);
            if (rstn && stage == 3) begin
                chk("rsp_y_vs_Ax", owner ? rsp_y_1 : rsp_y_0, sb_y);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_valid_0 = 1'b0;
            req_valid_1 = 1'b0;
        end
    endtask

    task automatic rand_req(input int r);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (r == 0) req_A_0[i][j] = $urandom();
                else        req_A_1[i][j] = $urandom();
            end
            if (r == 0) req_x_0[i] = $urandom();
            else        req_x_1[i] = $urandom();
        end
    endtask

    initial begin : stim
        mat_t idm;
        vec_t e1, bp;
        int rst_left;

        // Reset values
        repeat (2) @(negedge clk);
        #2;
        chk("rst_err", err, 1'b0);
        chk("rst_rsp_valid_0", rsp_valid_0, 1'b0);
        chk("rst_mv_i_dv", mv_i_dv, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        rsp_ready_0 = 1'b1;
        rsp_ready_1 = 1'b1;
        unit_delay = 5;

        // Single request: identity times {1,2,3,4}
        @(negedge clk);
        idm = '0;
        for (int i = 0; i < 4; i++) idm[i][i] = 1;
        req_A_0 = idm;
        for (int i = 0; i < 4; i++) begin
            req_x_0[i] = DW'(i + 1);
            e1[i] = DW'(i + 1);
        end
        req_valid_0 = 1'b1;
        #2 chk("d1_req_ready_0", req_ready_0, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            req_valid_0 = 1'b0;
            #2;
            chk("d1_rsp_valid_0", rsp_valid_0, k == 7);
            chk("d1_rsp_valid_1", rsp_valid_1, 1'b0);
        end
        chk("d1_rsp_y_0", rsp_y_0, e1);
        idle(2);

        // Back-pressure on requester 0 while requester 1 waits
        @(negedge clk);
        rsp_ready_0 = 1'b0;
        rand_req(0);
        rand_req(1);
        bp = mvmul(req_A_0, req_x_0);
        req_valid_0 = 1'b1;
        #2 chk("bp_req_ready_0", req_ready_0, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            req_valid_0 = 1'b0;
            req_valid_1 = 1'b1;
            #2 chk("bp_rsp_valid_0", rsp_valid_0, k == 7);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #2;
            chk("bp_no_issue", mv_i_dv, 1'b0);
            chk("bp_rsp_y_0", rsp_y_0, bp);
        end
        @(negedge clk);
        rsp_ready_0 = 1'b1;
        #2 chk("bp_hs_no_issue", mv_i_dv, 1'b0);
        @(negedge clk);
        #2 chk("bp_req_ready_1", req_ready_1, 1'b1);
        idle(10);

        // Unit never answers: timeout then a normal request
        @(negedge clk);
        unit_delay = 0;
        req_valid_1 = 1'b1;
        #2 chk("to_req_ready_1", req_ready_1, 1'b1);
        for (int k = 1; k <= TMO + 1; k++) begin
            @(negedge clk);
            req_valid_1 = 1'b0;
            #2;
            chk("to_err", err, k == TMO + 1);
            chk("to_rsp_valid_1", rsp_valid_1, 1'b0);
        end
        @(negedge clk);
        unit_delay = 5;
        req_valid_0 = 1'b1;
        #2 chk("to_next_issue", mv_i_dv, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            req_valid_0 = 1'b0;
            #2 chk("to_next_rsp", rsp_valid_0, k == 7);
        end
        chk("to_err_sticky", err, 1'b1);
        idle(2);

        // Unit not ready holds the request off
        @(negedge clk);
        mv_o_ready = 1'b0;
        req_valid_0 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #2 chk("nr_req_ready_0", req_ready_0, 1'b0);
            @(negedge clk);
        end
        mv_o_ready = 1'b1;
        #2 chk("nr_issue", req_ready_0, 1'b1);
        idle(1);

        // Reset two cycles after issue abandons the operation
        @(negedge clk);
        req_valid_0 = 1'b1;
        @(negedge clk);
        req_valid_0 = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #2;
        chk("rb_err", err, 1'b0);
        chk("rb_rsp_y_0", rsp_y_0, '0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #2 chk("rb_no_rsp", rsp_valid_0, 1'b0);
        end

        // Randomized traffic
        spur_en = 1'b1;
        rst_left = 0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) rstn = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                rstn = 1'b0;
                rst_left = $urandom_range(1, 3);
            end
            req_valid_0 = ($urandom_range(0, 9) < 6);
            req_valid_1 = ($urandom_range(0, 9) < 6);
            rand_req(0);
            rand_req(1);
            rsp_ready_0 = $urandom_range(0, 1);
            rsp_ready_1 = $urandom_range(0, 1);
            mv_o_ready = ($urandom_range(0, 19) < 17);
            unit_delay = $urandom_range(0, TMO + 1);
        end
        rstn = 1'b1;
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
